rect_draw_arbiter: RTL and testbench
====================================

Name: rect_draw_arbiter

Overview:
- Schedules rectangle-fill jobs from NUM_REQ independent UI clients onto the single shared rectangle drawer engine. The engine feeds the one vga_adapter pixel port.
- Clients are status bars, panels and cursors. Each presents a job (origin, size, colour). The arbiter picks one client round-robin, latches the job, starts the engine, waits for completion and reports it back to that client.
- Replaces per-screen hard-wired sequencing FSMs clocked from the engine's done strobe. Everything runs on clk.

Parameters:
- NUM_REQ, 4, number of requesting clients (2..8)
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width
- DIM_W, 10, width/height field width
- COL_W, 3, colour width
- TIMEOUT, 20'd400000, max clk cycles in WAIT before abort; 0 disables the watchdog

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  synchronous active-low reset
- req  in  NUM_REQ  per-client job request, level
- req_x  in  NUM_REQ*X_W  packed x origins, client i at [i*X_W +: X_W]
- req_y  in  NUM_REQ*Y_W  packed y origins
- req_w  in  NUM_REQ*DIM_W  packed widths
- req_h  in  NUM_REQ*DIM_W  packed heights
- req_colour  in  NUM_REQ*COL_W  packed colours
- ack  out  NUM_REQ  one-cycle pulse: client's job latched and started
- cmp  out  NUM_REQ  one-cycle pulse: client's job finished or aborted
- err  out  1  one-cycle pulse coincident with cmp when the job was aborted by timeout
- eng_start  out  1  one-cycle engine start pulse
- eng_x  out  X_W  latched job x, held from START through RETIRE
- eng_y  out  Y_W  latched job y, same hold rule
- eng_w  out  DIM_W  latched width, same hold rule
- eng_h  out  DIM_W  latched height, same hold rule
- eng_colour  out  COL_W  latched colour, same hold rule
- eng_done  in  1  engine completion pulse
- busy  out  1  high in every state except IDLE
- cur_id  out  3  id of the latched client; valid while busy

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer ptr=0, watchdog counter 0. Reset has priority in every state and aborts a job in flight silently: no cmp, no err. After reset, eng_start is not reasserted until a new grant.
- Registered datapath: all eng_* fields and cur_id are registered.
- States: IDLE, START, WAIT, RETIRE (2-bit encoding).
- IDLE:
  - If any req bit is set, grant the first set bit searching ptr, ptr+1, …, wrapping mod NUM_REQ.
  - On that edge: latch the client's fields and id, go to START. Otherwise stay in IDLE.
- START (exactly 1 cycle): assert ack[cur_id].
  - If eng_w==0 or eng_h==0: eng_start stays 0 and the next state is RETIRE (empty job, engine never started).
  - Otherwise: eng_start=1, clear the watchdog, next state is WAIT.
- WAIT:
  - Sample eng_done. eng_done=1 goes to RETIRE.
  - Otherwise the watchdog increments. When the count reaches TIMEOUT-1 (TIMEOUT≠0), go to RETIRE with the abort flag set.
  - eng_done and timeout in the same cycle count as normal completion (no err).
- RETIRE (1 cycle): cmp[cur_id]=1; err=abort flag. Set ptr=(cur_id+1) mod NUM_REQ, clear the abort flag, go to IDLE.
- Latency and throughput:
  - req seen in IDLE at cycle n gives ack/eng_start at n+1.
  - eng_done at cycle k gives cmp at k+1, and the arbiter is back in IDLE at k+2.
  - A new grant can happen in that IDLE cycle. Minimum 4 cycles per job; 3 cycles for an empty job.
- Engine sampling: eng_done is ignored outside WAIT, including a spurious pulse in START or IDLE. The engine must not assert done in the same cycle as start.
- Client contract:
  - Hold req and fields stable until ack.
  - Dropping req before grant withdraws the job; only the req value in the IDLE grant cycle matters.
  - Fields may change after ack without affecting the job in flight.
  - A client keeping req high after ack re-requests and competes again under round-robin. It cannot be granted twice in a row while others are requesting.
- Out-of-range NUM_REQ (outside 2..8): treated as undefined configuration.

Test Plan:
- Single job: after reset, req[1]=1 with x=195, y=95, w=75, h=10, colour=3'b010.
  - ack[1] and eng_start at the next cycle, eng_x=195, eng_y=95, busy=1.
  - Engine model gives done 750 cycles after start → cmp[1] one cycle after done, busy=0 one cycle later.
- Contention: req[0] and req[2] high together from reset, constant.
  - Grant order 0,2,0,2.
  - With all four high, order 0,1,2,3,0; no client granted twice consecutively.
- Empty job: req[3] with w=0, h=10.
  - ack[3] with eng_start never asserted, cmp[3] one cycle after ack, err=0.
- Timeout: TIMEOUT=16, engine never asserts done.
  - cmp and err pulse together 16 cycles after START; next request is then served normally.
- Reset mid-WAIT: resetn=0 for 1 cycle during a job.
  - All outputs 0 next cycle, no cmp/err for the aborted job, ptr back to 0 (client 0 wins next tie).
- Spurious done: eng_done pulsed while IDLE and during START.
  - No state change and no cmp; WAIT still requires a real done.

Source files
------------

// File: rtl/rect_draw_arbiter.sv
// Round-robin scheduler sharing one rectangle-fill engine among NUM_REQ UI clients.
// A job is latched on grant, the engine is started and watched, then completion is reported back.
module rect_draw_arbiter #(
  parameter int          NUM_REQ = 4,
  parameter int          X_W     = 10,
  parameter int          Y_W     = 9,
  parameter int          DIM_W   = 10,
  parameter int          COL_W   = 3,
  parameter logic [19:0] TIMEOUT = 20'd400000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*X_W-1:0]     req_x,
  input  logic [NUM_REQ*Y_W-1:0]     req_y,
  input  logic [NUM_REQ*DIM_W-1:0]   req_w,
  input  logic [NUM_REQ*DIM_W-1:0]   req_h,
  input  logic [NUM_REQ*COL_W-1:0]   req_colour,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         cmp,
  output logic                       err,
  output logic                       eng_start,
  output logic [X_W-1:0]             eng_x,
  output logic [Y_W-1:0]             eng_y,
  output logic [DIM_W-1:0]           eng_w,
  output logic [DIM_W-1:0]           eng_h,
  output logic [COL_W-1:0]           eng_colour,
  input  logic                       eng_done,
  output logic                       busy,
  output logic [2:0]                 cur_id
);

  // state  | meaning
  // IDLE   | no job; grant the next requester round-robin from ptr
  // START  | ack the client; pulse eng_start unless the job is empty
  // WAIT   | engine running; watch eng_done and the watchdog
  // RETIRE | pulse cmp (and err if aborted); advance ptr past this client
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETIRE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [2:0]         ptr;
  logic [19:0]        wd_cnt;
  logic               abort;

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] req_hi;
  logic               gnt_vld;
  logic [2:0]         gnt_id;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [DIM_W-1:0]   sel_w;
  logic [DIM_W-1:0]   sel_h;
  logic [COL_W-1:0]   sel_colour;

  logic               empty_job;
  logic               tmo_hit;

  // Requests at or above ptr win first; otherwise wrap to the lowest set bit.
  always_comb begin
    hi_mask    = '0;
    gnt_vld    = |req;
    gnt_id     = '0;
    sel_x      = '0;
    sel_y      = '0;
    sel_w      = '0;
    sel_h      = '0;
    sel_colour = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (3'(i) >= ptr);
    end
    req_hi = req & hi_mask;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) gnt_id = 3'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_hi[i]) gnt_id = 3'(i);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == 3'(i)) begin
        sel_x      = req_x[i*X_W +: X_W];
        sel_y      = req_y[i*Y_W +: Y_W];
        sel_w      = req_w[i*DIM_W +: DIM_W];
        sel_h      = req_h[i*DIM_W +: DIM_W];
        sel_colour = req_colour[i*COL_W +: COL_W];
      end
    end
  end

  assign empty_job = (eng_w == '0) || (eng_h == '0);
  // Fires on the WAIT cycle whose increment brings the count to TIMEOUT-1.
  assign tmo_hit   = (TIMEOUT != 20'd0) && (({1'b0, wd_cnt} + 21'd2) >= {1'b0, TIMEOUT});

  always_comb begin
    state_nxt = state;
    ack       = '0;
    cmp       = '0;
    err       = 1'b0;
    eng_start = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (gnt_vld) state_nxt = S_START;
      end
      S_START: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          ack[i] = (cur_id == 3'(i));
        end
        if (empty_job) begin
          state_nxt = S_RETIRE;
        end else begin
          eng_start = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_done || tmo_hit) state_nxt = S_RETIRE;
      end
      S_RETIRE: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          cmp[i] = (cur_id == 3'(i));
        end
        err       = abort;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cur_id     <= '0;
      wd_cnt     <= '0;
      abort      <= 1'b0;
      eng_x      <= '0;
      eng_y      <= '0;
      eng_w      <= '0;
      eng_h      <= '0;
      eng_colour <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            cur_id     <= gnt_id;
            eng_x      <= sel_x;
            eng_y      <= sel_y;
            eng_w      <= sel_w;
            eng_h      <= sel_h;
            eng_colour <= sel_colour;
          end
        end
        S_START: begin
          wd_cnt <= '0;
          abort  <= 1'b0;
        end
        S_WAIT: begin
          // A done arriving with the timeout counts as a normal finish.
          if (!eng_done) begin
            wd_cnt <= wd_cnt + 20'd1;
            if (tmo_hit) abort <= 1'b1;
          end
        end
        S_RETIRE: begin
          ptr   <= (({1'b0, cur_id} + 4'd1) == 4'(NUM_REQ)) ? 3'd0 : cur_id + 3'd1;
          abort <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// Directed and randomized checks of rect_draw_arbiter against a job-level round-robin model.
// A second instance with a short watchdog covers the timeout path.
module tb_rect_draw_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req, req_t;
  logic [N*10-1:0] req_x;
  logic [N*9-1:0]  req_y;
  logic [N*10-1:0] req_w, req_h;
  logic [N*3-1:0]  req_colour;

  logic [N-1:0] ack, cmp, ack_t, cmp_t;
  logic         err, eng_start, eng_done, busy;
  logic         err_t, eng_start_t, done_t, busy_t;
  logic [9:0]   eng_x, eng_w, eng_h, eng_x_t, eng_w_t, eng_h_t;
  logic [8:0]   eng_y, eng_y_t;
  logic [2:0]   eng_colour, eng_colour_t, cur_id, cur_id_t;

  rect_draw_arbiter u_dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .ack(ack), .cmp(cmp),
    .err(err), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_w(eng_w),
    .eng_h(eng_h), .eng_colour(eng_colour), .eng_done(eng_done), .busy(busy),
    .cur_id(cur_id)
  );

  rect_draw_arbiter #(.TIMEOUT(20'd16)) u_tmo (
    .clk(clk), .resetn(resetn), .req(req_t), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .ack(ack_t), .cmp(cmp_t),
    .err(err_t), .eng_start(eng_start_t), .eng_x(eng_x_t), .eng_y(eng_y_t), .eng_w(eng_w_t),
    .eng_h(eng_h_t), .eng_colour(eng_colour_t), .eng_done(done_t), .busy(busy_t),
    .cur_id(cur_id_t)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int model_ptr = 0;

  logic [9:0] fx[N];
  logic [8:0] fy[N];
  logic [9:0] fw[N];
  logic [9:0] fh[N];
  logic [2:0] fc[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      req_x[i*10 +: 10]    = fx[i];
      req_y[i*9 +: 9]      = fy[i];
      req_w[i*10 +: 10]    = fw[i];
      req_h[i*10 +: 10]    = fh[i];
      req_colour[i*3 +: 3] = fc[i];
    end
  endtask

  task automatic set_job(input int id, input int x, input int y, input int w, input int h, input int c);
    fx[id] = 10'(x);
    fy[id] = 9'(y);
    fw[id] = 10'(w);
    fh[id] = 10'(h);
    fc[id] = 3'(c);
    drive_fields();
  endtask

  task automatic random_fields();
    for (int i = 0; i < N; i++) begin
      fx[i] = 10'($urandom_range(0, 1023));
      fy[i] = 9'($urandom_range(0, 511));
      fw[i] = ($urandom_range(0, 6) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      fh[i] = ($urandom_range(0, 6) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      fc[i] = 3'($urandom_range(0, 7));
    end
    drive_fields();
  endtask

  // Round-robin rule: first requester found scanning ptr, ptr+1, ... mod N.
  function automatic int model_grant(input int ptr, input logic [N-1:0] r);
    int id;
    for (int k = 0; k < N; k++) begin
      id = (ptr + k) % N;
      if (r[id]) return id;
    end
    return -1;
  endfunction

  // Called in an IDLE cycle with req already driven; returns in the following IDLE cycle.
  task automatic run_job(input int exp_id, input int lat, input bit spur, input bit scramble);
    logic [9:0] ex, ew, eh;
    logic [8:0] ey;
    logic [2:0] ec;
    bit         empty;
    ex = fx[exp_id]; ey = fy[exp_id]; ew = fw[exp_id]; eh = fh[exp_id]; ec = fc[exp_id];
    empty = (ew == 10'd0) || (eh == 10'd0);
    tick();
    chk("ack", 32'(ack), 32'(1 << exp_id));
    chk("eng_start", 32'(eng_start), 32'(!empty));
    chk("cur_id", 32'(cur_id), 32'(exp_id));
    chk("eng_x", 32'(eng_x), 32'(ex));
    chk("eng_y", 32'(eng_y), 32'(ey));
    chk("eng_w", 32'(eng_w), 32'(ew));
    chk("eng_h", 32'(eng_h), 32'(eh));
    chk("eng_colour", 32'(eng_colour), 32'(ec));
    chk("busy_start", 32'(busy), 32'd1);
    chk("cmp_start", 32'(cmp), 32'd0);
    if (scramble) random_fields();
    if (spur) eng_done = 1'b1;
    if (!empty) begin
      tick();
      eng_done = 1'b0;
      chk("cmp_wait", 32'(cmp), 32'd0);
      chk("busy_wait", 32'(busy), 32'd1);
      repeat (lat - 1) tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
    end else begin
      tick();
      eng_done = 1'b0;
    end
    chk("cmp", 32'(cmp), 32'(1 << exp_id));
    chk("err", 32'(err), 32'd0);
    chk("ack_retire", 32'(ack), 32'd0);
    chk("eng_start_retire", 32'(eng_start), 32'd0);
    chk("eng_x_hold", 32'(eng_x), 32'(ex));
    chk("eng_colour_hold", 32'(eng_colour), 32'(ec));
    model_ptr = (exp_id + 1) % N;
    tick();
    chk("busy_idle", 32'(busy), 32'd0);
    chk("cmp_idle", 32'(cmp), 32'd0);
  endtask

  initial begin
    logic [N-1:0] r;
    int           g;
    int           lat;
    bit           spur, scr;

    req = '0; req_t = '0; eng_done = 1'b0; done_t = 1'b0;
    for (int i = 0; i < N; i++) set_job(i, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_cmp", 32'(cmp), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cur_id", 32'(cur_id), 32'd0);
    chk("rst_eng_x", 32'(eng_x), 32'd0);
    chk("rst_busy_t", 32'(busy_t), 32'd0);
    resetn = 1'b1;
    model_ptr = 0;

    // Single job with a long engine run
    set_job(1, 195, 95, 75, 10, 3'b010);
    req = 4'b0010;
    run_job(1, 750, 1'b0, 1'b0);
    req = '0;

    // Two clients contending from reset
    set_job(0, 10, 20, 30, 40, 1);
    set_job(2, 50, 60, 70, 80, 2);
    resetn = 1'b0; req = 4'b0101;
    tick();
    resetn = 1'b1; model_ptr = 0;
    run_job(0, 3, 1'b0, 1'b0);
    run_job(2, 2, 1'b0, 1'b0);
    run_job(0, 1, 1'b0, 1'b0);
    run_job(2, 4, 1'b0, 1'b0);

    // All four contending after a fresh reset
    set_job(1, 11, 12, 13, 14, 3);
    set_job(3, 21, 22, 23, 24, 4);
    resetn = 1'b0; req = 4'b1111;
    tick();
    resetn = 1'b1; model_ptr = 0;
    run_job(0, 2, 1'b0, 1'b0);
    run_job(1, 2, 1'b0, 1'b0);
    run_job(2, 2, 1'b0, 1'b0);
    run_job(3, 2, 1'b0, 1'b0);
    run_job(0, 2, 1'b0, 1'b0);
    req = '0;

    // Empty job: engine never started
    set_job(3, 5, 5, 0, 10, 1);
    req = 4'b1000;
    run_job(3, 1, 1'b0, 1'b0);
    req = '0;

    // Spurious done in IDLE, then in START
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("spur_idle_busy", 32'(busy), 32'd0);
    chk("spur_idle_cmp", 32'(cmp), 32'd0);
    tick();
    chk("spur_idle_ack", 32'(ack), 32'd0);
    set_job(2, 100, 100, 4, 4, 6);
    req = 4'b0100;
    run_job(2, 5, 1'b1, 1'b1);
    req = '0;

    // Reset in the middle of WAIT
    set_job(1, 33, 44, 55, 66, 7);
    set_job(2, 77, 88, 99, 11, 5);
    req = 4'b0010;
    run_job(1, 3, 1'b0, 1'b0);
    req = 4'b0100;
    tick();
    req = '0;
    repeat (2) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_cmp", 32'(cmp), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_eng_start", 32'(eng_start), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cur_id", 32'(cur_id), 32'd0);
    chk("mid_rst_eng_x", 32'(eng_x), 32'd0);
    chk("mid_rst_eng_y", 32'(eng_y), 32'd0);
    chk("mid_rst_eng_w", 32'(eng_w), 32'd0);
    chk("mid_rst_eng_h", 32'(eng_h), 32'd0);
    chk("mid_rst_eng_colour", 32'(eng_colour), 32'd0);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("mid_rst_late_cmp", 32'(cmp), 32'd0);
    chk("mid_rst_late_busy", 32'(busy), 32'd0);
    tick();
    chk("mid_rst_late_err", 32'(err), 32'd0);
    model_ptr = 0;
    req = 4'b1111;
    run_job(0, 2, 1'b0, 1'b0);
    req = '0;

    // Randomized jobs against the round-robin model
    for (int it = 0; it < 60; it++) begin
      random_fields();
      r = 4'($urandom_range(1, 15));
      req = r;
      g = model_grant(model_ptr, r);
      lat = $urandom_range(1, 12);
      spur = 1'($urandom_range(0, 1));
      scr = 1'($urandom_range(0, 1));
      run_job(g, lat, spur, scr);
    end
    req = '0;

    // Watchdog abort on the short-timeout instance
    set_job(0, 10, 20, 30, 40, 5);
    req_t = 4'b0001;
    tick();
    chk("tmo_ack", 32'(ack_t), 32'd1);
    chk("tmo_eng_start", 32'(eng_start_t), 32'd1);
    req_t = '0;
    repeat (15) tick();
    chk("tmo_cmp_early", 32'(cmp_t), 32'd0);
    chk("tmo_busy_early", 32'(busy_t), 32'd1);
    tick();
    chk("tmo_cmp", 32'(cmp_t), 32'd1);
    chk("tmo_err", 32'(err_t), 32'd1);
    tick();
    chk("tmo_idle_busy", 32'(busy_t), 32'd0);
    chk("tmo_idle_err", 32'(err_t), 32'd0);

    set_job(1, 1, 2, 3, 4, 6);
    req_t = 4'b0010;
    tick();
    chk("post_tmo_ack", 32'(ack_t), 32'd2);
    chk("post_tmo_eng_start", 32'(eng_start_t), 32'd1);
    req_t = '0;
    repeat (3) tick();
    done_t = 1'b1;
    tick();
    done_t = 1'b0;
    chk("post_tmo_cmp", 32'(cmp_t), 32'd2);
    chk("post_tmo_err", 32'(err_t), 32'd0);
    tick();
    chk("post_tmo_busy", 32'(busy_t), 32'd0);

    // Done arriving on the timeout cycle is a normal finish
    set_job(2, 9, 9, 9, 9, 1);
    req_t = 4'b0100;
    tick();
    chk("coinc_ack", 32'(ack_t), 32'd4);
    req_t = '0;
    repeat (15) tick();
    chk("coinc_cmp_early", 32'(cmp_t), 32'd0);
    done_t = 1'b1;
    tick();
    done_t = 1'b0;
    chk("coinc_cmp", 32'(cmp_t), 32'd4);
    chk("coinc_err", 32'(err_t), 32'd0);
    tick();
    chk("coinc_busy", 32'(busy_t), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
